sample_accum: RTL and testbench
===============================

# sample_accum

Consumes the per-sample strobe `sp_en` from the trigger/sampling FSM together with the ADC data word. Collects exactly `SP_NUM` samples into one frame and computes the frame sum, minimum and maximum. Presents each finished frame on a one-deep valid/ready output. Partial frames are discarded by an inactivity timeout, and frames that arrive while the output is still occupied are dropped and flagged.

## Interface
- `DW`, 12: ADC sample width.
- `SP_NUM`, 6: samples per frame, ≥1. Must match the sampling FSM.
- `TIMEOUT`, 16'd2000: idle cycles inside a frame before abort (10 µs at 200 MHz). 16-bit.
- Derived localparam `SW = DW + $clog2(SP_NUM+1)`: sum width (15 at defaults).
- `clk` in 1: single clock, 200 MHz.
- `rst` in 1: synchronous, active-high reset.
- `sp_en` in 1: sample strobe; `adc_data` is captured on every edge where this is high.
- `adc_data` in DW: unsigned ADC sample.
- `frm_valid` out 1: frame record available.
- `frm_ready` in 1: consumer accepts the record.
- `frm_sum` out SW: sum of the frame's samples.
- `frm_min` out DW: minimum sample in the frame.
- `frm_max` out DW: maximum sample in the frame.
- `ovf_err` out 1: one-cycle pulse when a completed frame is dropped.
- `tmo_err` out 1: one-cycle pulse when a partial frame is aborted.
- `busy` out 1: a frame is in progress or a sample is in the pipe.

## Operation
- Stage 1 (capture): on an edge with `sp_en=1`, register `adc_data` into `s_data` and set `s_vld=1`. Otherwise `s_vld=0`.
- Stage 2 (accumulate): FSM with states IDLE and ACC. Sample counter `cnt` has width `$clog2(SP_NUM+1)`.
- IDLE, `s_vld`:
  - Load `sum=s_data`, `min=max=s_data`, `cnt=1`.
  - Go to ACC. If `SP_NUM==1`, complete immediately instead.
- ACC, `s_vld`:
  - Update `sum+=s_data`.
  - Update `min`/`max` by unsigned compare.
  - Increment `cnt`.
- Completion: the edge that would make `cnt==SP_NUM`.
  - Final values include that sample.
  - FSM returns to IDLE and `cnt` clears.
- Hand-off at completion:
  - If the output register is empty, or is being transferred this cycle (`frm_valid & frm_ready`), load it with the final values and set `frm_valid=1`.
  - Otherwise keep the old record, discard the new one and pulse `ovf_err`.
- Timeout:
  - In ACC, `idle_cnt` increments each cycle without `s_vld` and clears on `s_vld`.
  - When it reaches `TIMEOUT`, discard the partial frame, pulse `tmo_err` and return to IDLE.
  - `s_vld` in the same cycle wins: the sample is accumulated and no timeout occurs.
- Output handshake:
  - A transfer happens on an edge with `frm_valid & frm_ready`.
  - `frm_valid` clears unless it is reloaded on the same edge.
  - `frm_sum/min/max` are stable while `frm_valid & !frm_ready`.
- `busy = (state==ACC) | s_vld`.
- Width: `SW` guarantees no sum overflow, since `SP_NUM*(2^DW-1) < 2^SW`. No saturation logic.

## Timing
- Reset values (outputs 0 from the edge where `rst=1`):
  - Outputs: `frm_valid`, `frm_sum`, `frm_min`, `frm_max`, `ovf_err`, `tmo_err` and `busy` all 0.
  - Internal: state IDLE, `cnt`, `idle_cnt` and `s_vld` all 0.
- Latency: last `sp_en` sampled at edge k → `frm_valid` high after edge k+2 (2 cycles).
- Back-to-back strobes (`sp_en` every cycle) are fully supported with no dropped samples.
- `ovf_err` and `tmo_err` assert for exactly one cycle, in the cycle after the causing edge.
- A new frame may begin in the same edge that completes the previous one only if they are separate samples. One sample belongs to one frame.
- Reset mid-frame: the partial frame and any held record are lost. No error pulse.

## Structure
- Package `sample_pkg`:
  - enum `acc_state_t` {IDLE, ACC}.
  - struct `frame_t` {sum, min, max}, parameterised by the `DW` default.
  - default localparams `SP_NUM` and `TIMEOUT`, shared with the sampling FSM.
- One sub-module, `frame_out_reg`: a one-deep valid/ready holding register.
  - Inputs: `load`, `frame_t`.
  - Output: `free = !valid | ready`.
  - Drives `frm_*`. Used by the accumulator to decide between accept and `ovf_err`.

## Test plan
- Samples 100..105, one `sp_en` every 5 cycles, `frm_ready=1`:
  - `frm_sum=615`, `min=100`, `max=105`.
  - `frm_valid` high 1 cycle, 2 cycles after the last strobe.
- Six back-to-back `sp_en` with all samples 4095 → `frm_sum=24570`, `min=max=4095`, no errors.
- `frm_ready=0`, two full frames (sums 600 then 1200):
  - Second completion pulses `ovf_err`.
  - Output holds sum 600.
  - After `frm_ready=1`, exactly one transfer of 600.
- Output held, and `frm_ready` rises in the same cycle the second frame completes → no `ovf_err`; the new record is valid on the next cycle.
- Three samples, then silence:
  - `tmo_err` pulses 2000 cycles after the last sample, with no `frm_valid`.
  - The following 6 samples (10 each) give `frm_sum=60`.
- `rst` asserted after 3 samples → all outputs 0 next cycle; the subsequent full frame is correct and has no error pulses.

Source files
------------

// File: rtl/sample_pkg.sv
// Shared types and default parameters for the sampling front end.
//   acc_state_t : accumulator FSM states
//   frame_t     : one finished frame record {sum, min, max} at default widths
//   DW, SP_NUM, TIMEOUT, SW : defaults shared with the sampling FSM
package sample_pkg;

  localparam int unsigned DW      = 12;
  localparam int unsigned SP_NUM  = 6;
  localparam logic [15:0] TIMEOUT = 16'd2000;
  localparam int unsigned SW      = DW + $clog2(SP_NUM + 1);

  typedef enum logic {
    IDLE,
    ACC
  } acc_state_t;

  typedef struct packed {
    logic [SW-1:0] sum;
    logic [DW-1:0] min;
    logic [DW-1:0] max;
  } frame_t;

endpackage

// File: rtl/sample_accum_if.sv
// Frame output bus: one-deep valid/ready record carrying sum, min and max.
//   master : producer (sample_accum) drives frm_valid/frm_sum/frm_min/frm_max
//   slave  : consumer drives frm_ready
interface sample_accum_if #(
  parameter int unsigned DW = sample_pkg::DW,
  parameter int unsigned SW = sample_pkg::SW
);

  logic          frm_valid;
  logic          frm_ready;
  logic [SW-1:0] frm_sum;
  logic [DW-1:0] frm_min;
  logic [DW-1:0] frm_max;

  modport master (
    output frm_valid,
    output frm_sum,
    output frm_min,
    output frm_max,
    input  frm_ready
  );

  modport slave (
    input  frm_valid,
    input  frm_sum,
    input  frm_min,
    input  frm_max,
    output frm_ready
  );

endinterface

// File: rtl/frame_out_reg.sv
// One-deep valid/ready holding register for finished frame records.
//   clk, rst : clock, synchronous active-high reset
//   load_i   : capture frame_i (only asserted while free_o is high)
//   frame_i  : record to capture
//   ready_i  : consumer accepts the held record this cycle
//   valid_o  : a record is held
//   frame_o  : held record, stable while valid_o & !ready_i
//   free_o   : register can take a new record on this edge
module frame_out_reg
  import sample_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  frame_t frame_i,
  input  logic   ready_i,
  output logic   valid_o,
  output frame_t frame_o,
  output logic   free_o
);

  logic   valid_q;
  frame_t frame_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      frame_q <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      frame_q <= frame_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign frame_o = frame_q;
  assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/sample_accum.sv
// Frame accumulator: collects SP_NUM strobed ADC samples per frame and
// produces sum/min/max on a one-deep valid/ready output.
//   clk, rst  : 200 MHz clock, synchronous active-high reset
//   sp_en     : sample strobe, adc_data captured when high
//   adc_data  : unsigned ADC sample
//   frm       : frame output bus (master side)
//   ovf_err   : one-cycle pulse, finished frame dropped (output occupied)
//   tmo_err   : one-cycle pulse, partial frame aborted after TIMEOUT idle cycles
//   busy      : frame in progress or sample in the capture stage
// DW must equal sample_pkg::DW since the frame record type follows it.
module sample_accum #(
  parameter int unsigned DW      = sample_pkg::DW,
  parameter int unsigned SP_NUM  = sample_pkg::SP_NUM,
  parameter logic [15:0] TIMEOUT = sample_pkg::TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sp_en,
  input  logic [DW-1:0]        adc_data,
  sample_accum_if.master       frm,
  output logic                 ovf_err,
  output logic                 tmo_err,
  output logic                 busy
);

  import sample_pkg::*;

  localparam int unsigned CW = $clog2(SP_NUM + 1);
  localparam int unsigned SW = DW + CW;

  logic          s_vld_q;
  logic [DW-1:0] s_data_q;

  acc_state_t    state_q;
  logic [CW-1:0] cnt_q;
  logic [15:0]   idle_q;
  logic [SW-1:0] sum_q;
  logic [DW-1:0] min_q;
  logic [DW-1:0] max_q;
  logic          done_q;
  logic          ovf_q;
  logic          tmo_q;

  logic          last;
  logic          out_free;
  logic          out_load;
  logic          out_valid;
  frame_t        fin;
  frame_t        out_frame;

  assign last = (cnt_q == CW'(SP_NUM - 1));

  // sum/min/max hold the finished frame for one cycle after completion;
  // a new frame's first sample overwrites them on the same edge that the
  // hand-off reads them, which is safe since reads see pre-edge values.
  assign fin      = '{sum: sum_q, min: min_q, max: max_q};
  assign out_load = done_q && out_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_vld_q  <= 1'b0;
      s_data_q <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      idle_q   <= '0;
      sum_q    <= '0;
      min_q    <= '0;
      max_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      s_vld_q <= sp_en;
      if (sp_en) s_data_q <= adc_data;

      done_q <= 1'b0;
      tmo_q  <= 1'b0;
      ovf_q  <= done_q && !out_free;

      case (state_q)
        IDLE: begin
          idle_q <= '0;
          if (s_vld_q) begin
            sum_q <= SW'(s_data_q);
            min_q <= s_data_q;
            max_q <= s_data_q;
            if (SP_NUM == 1) begin
              done_q <= 1'b1;
              cnt_q  <= '0;
            end else begin
              cnt_q   <= CW'(1);
              state_q <= ACC;
            end
          end
        end
        ACC: begin
          if (s_vld_q) begin
            // a sample arriving as idle_q would hit TIMEOUT still counts
            idle_q <= '0;
            sum_q  <= sum_q + SW'(s_data_q);
            if (s_data_q < min_q) min_q <= s_data_q;
            if (s_data_q > max_q) max_q <= s_data_q;
            if (last) begin
              done_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else if ((idle_q + 16'd1) == TIMEOUT) begin
            tmo_q   <= 1'b1;
            idle_q  <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            idle_q <= idle_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  frame_out_reg u_out (
    .clk     (clk),
    .rst     (rst),
    .load_i  (out_load),
    .frame_i (fin),
    .ready_i (frm.frm_ready),
    .valid_o (out_valid),
    .frame_o (out_frame),
    .free_o  (out_free)
  );

  assign frm.frm_valid = out_valid;
  assign frm.frm_sum   = out_frame.sum;
  assign frm.frm_min   = out_frame.min;
  assign frm.frm_max   = out_frame.max;

  assign ovf_err = ovf_q;
  assign tmo_err = tmo_q;
  assign busy    = (state_q == ACC) || s_vld_q;

endmodule

// File: tb/tb_sample_accum.sv
module tb_sample_accum;

  localparam int unsigned TDW  = 12;
  localparam int unsigned TSW  = 15;
  localparam int unsigned TSP  = 6;
  localparam int unsigned TTMO = 2000;

  typedef struct {
    int unsigned cyc;
    logic [31:0] sum;
    logic [31:0] mn;
    logic [31:0] mx;
  } rec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           sp_en = 1'b0;
  logic [TDW-1:0] adc_data = '0;
  logic           ovf_err;
  logic           tmo_err;
  logic           busy;

  sample_accum_if #(.DW(TDW), .SW(TSW)) fif ();

  sample_accum #(
    .DW      (TDW),
    .SP_NUM  (TSP),
    .TIMEOUT (16'(TTMO))
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sp_en    (sp_en),
    .adc_data (adc_data),
    .frm      (fif),
    .ovf_err  (ovf_err),
    .tmo_err  (tmo_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // observed transfers and error pulses, stamped with the last edge index
  rec_t        xq[$];
  int unsigned ovfs[$];
  int unsigned tmos[$];
  int unsigned valid_cycles = 0;

  always @(negedge clk) begin
    rec_t r;
    if (fif.frm_valid === 1'b1) valid_cycles++;
    if (fif.frm_valid === 1'b1 && fif.frm_ready === 1'b1) begin
      r.cyc = cyc;
      r.sum = 32'(fif.frm_sum);
      r.mn  = 32'(fif.frm_min);
      r.mx  = 32'(fif.frm_max);
      xq.push_back(r);
    end
    if (ovf_err === 1'b1) ovfs.push_back(cyc);
    if (tmo_err === 1'b1) tmos.push_back(cyc);
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input int unsigned d);
    sp_en    = 1'b1;
    adc_data = TDW'(d);
    tick();
    sp_en    = 1'b0;
  endtask

  task automatic wait_xfers(input string tag, input int n, input int budget);
    int b = 0;
    while (xq.size() < n && b < budget) begin
      tick();
      b++;
    end
    check(tag, xq.size(), n);
  endtask

  task automatic clear_logs();
    xq.delete();
    ovfs.delete();
    tmos.delete();
    valid_cycles = 0;
  endtask

  function automatic rec_t xget(input int i);
    rec_t r;
    r = '{cyc: 0, sum: '1, mn: '1, mx: '1};
    if (i < xq.size()) r = xq[i];
    return r;
  endfunction

  function automatic int unsigned qget(input int unsigned q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hFFFF_FFFF;
  endfunction

  // reference: frame statistics straight from the sample list
  function automatic rec_t model(input int unsigned s[$]);
    rec_t r;
    r.cyc = 0;
    r.sum = 0;
    r.mn  = s[0];
    r.mx  = s[0];
    foreach (s[i]) begin
      r.sum += s[i];
      if (s[i] < r.mn) r.mn = s[i];
      if (s[i] > r.mx) r.mx = s[i];
    end
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(fif.frm_valid), 0);
    check({tag, "_sum"},   32'(fif.frm_sum),   0);
    check({tag, "_min"},   32'(fif.frm_min),   0);
    check({tag, "_max"},   32'(fif.frm_max),   0);
    check({tag, "_ovf"},   32'(ovf_err),       0);
    check({tag, "_tmo"},   32'(tmo_err),       0);
    check({tag, "_busy"},  32'(busy),          0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  int unsigned last;
  int unsigned s[$];
  rec_t        exp_q[$];
  rec_t        e;
  rec_t        g;
  int          b;

  initial begin
    fif.frm_ready = 1'b1;

    // reset
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // 100..105, one strobe every 5 cycles
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      strobe(100 + i);
      if (i == 0) check("busy_active", 32'(busy), 1);
      if (i < 5) idle(4);
    end
    last = cyc;
    wait_xfers("t1_xfer", 1, 20);
    idle(5);
    g = xget(0);
    check("t1_sum", g.sum, 615);
    check("t1_min", g.mn, 100);
    check("t1_max", g.mx, 105);
    check("t1_latency", g.cyc, last + 2);
    check("t1_valid_cycles", valid_cycles, 1);
    check("t1_busy_idle", 32'(busy), 0);
    check("t1_errs", ovfs.size() + tmos.size(), 0);

    // back-to-back full-scale samples
    clear_logs();
    for (int i = 0; i < 6; i++) strobe(4095);
    last = cyc;
    wait_xfers("t2_xfer", 1, 20);
    g = xget(0);
    check("t2_sum", g.sum, 24570);
    check("t2_min", g.mn, 4095);
    check("t2_max", g.mx, 4095);
    check("t2_latency", g.cyc, last + 2);
    check("t2_errs", ovfs.size() + tmos.size(), 0);

    // random frames, random short gaps (including none between frames)
    clear_logs();
    exp_q.delete();
    for (int f = 0; f < 6; f++) begin
      s.delete();
      for (int j = 0; j < 6; j++) begin
        idle($urandom_range(0, 3));
        s.push_back($urandom_range(0, 4095));
        strobe(s[j]);
      end
      exp_q.push_back(model(s));
    end
    wait_xfers("t3_xfer", 6, 40);
    for (int f = 0; f < 6; f++) begin
      g = xget(f);
      check("t3_sum", g.sum, exp_q[f].sum);
      check("t3_min", g.mn, exp_q[f].mn);
      check("t3_max", g.mx, exp_q[f].mx);
    end
    check("t3_errs", ovfs.size() + tmos.size(), 0);

    // output held: second frame dropped
    fif.frm_ready = 1'b0;
    clear_logs();
    for (int i = 0; i < 6; i++) strobe(100);
    for (int i = 0; i < 6; i++) strobe(200);
    last = cyc;
    idle(6);
    check("t4_ovf_count", ovfs.size(), 1);
    check("t4_ovf_time", qget(ovfs, 0), last + 2);
    check("t4_held_valid", 32'(fif.frm_valid), 1);
    check("t4_held_sum", 32'(fif.frm_sum), 600);
    check("t4_no_xfer", xq.size(), 0);
    fif.frm_ready = 1'b1;
    idle(5);
    check("t4_one_xfer", xq.size(), 1);
    g = xget(0);
    check("t4_xfer_sum", g.sum, 600);
    check("t4_valid_after", 32'(fif.frm_valid), 0);

    // ready rises on the edge the second frame is handed off
    fif.frm_ready = 1'b0;
    clear_logs();
    for (int i = 0; i < 6; i++) strobe(100);
    idle(3);
    for (int i = 0; i < 6; i++) strobe(50);
    tick();
    fif.frm_ready = 1'b1;
    tick();
    fif.frm_ready = 1'b0;
    @(negedge clk);
    check("t5_valid", 32'(fif.frm_valid), 1);
    check("t5_sum", 32'(fif.frm_sum), 300);
    check("t5_ovf", ovfs.size(), 0);
    check("t5_first_xfer", xget(0).sum, 600);
    @(posedge clk);
    #1;
    fif.frm_ready = 1'b1;
    wait_xfers("t5_xfer", 2, 10);
    g = xget(1);
    check("t5_second_sum", g.sum, 300);
    check("t5_second_max", g.mx, 50);

    // inactivity timeout
    clear_logs();
    strobe(7);
    idle(1);
    strobe(8);
    idle(1);
    strobe(9);
    last = cyc;
    b = 0;
    while (tmos.size() == 0 && b < int'(TTMO) + 50) begin
      tick();
      b++;
    end
    check("t6_tmo_count", tmos.size(), 1);
    check("t6_tmo_time", qget(tmos, 0), last + 1 + TTMO);
    check("t6_no_frame", xq.size(), 0);
    tick();
    check("t6_busy_after", 32'(busy), 0);
    for (int i = 0; i < 6; i++) begin
      strobe(10);
      idle(2);
    end
    wait_xfers("t6_xfer", 1, 20);
    g = xget(0);
    check("t6_sum", g.sum, 60);
    check("t6_min", g.mn, 10);
    check("t6_tmo_total", tmos.size(), 1);

    // sample arrives exactly as the idle count would expire
    clear_logs();
    s.delete();
    s.push_back(1);
    strobe(1);
    idle(TTMO - 1);
    s.push_back(2);
    strobe(2);
    for (int i = 0; i < 4; i++) begin
      s.push_back(3);
      strobe(3);
    end
    e = model(s);
    wait_xfers("t7_xfer", 1, 20);
    g = xget(0);
    check("t7_no_tmo", tmos.size(), 0);
    check("t7_sum", g.sum, e.sum);
    check("t7_min", g.mn, e.mn);
    check("t7_max", g.mx, e.mx);

    // reset mid-frame with a record held
    fif.frm_ready = 1'b0;
    clear_logs();
    for (int i = 0; i < 6; i++) strobe(5);
    idle(3);
    for (int i = 0; i < 3; i++) strobe(20);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    fif.frm_ready = 1'b1;
    clear_logs();
    for (int i = 1; i <= 6; i++) strobe(i);
    wait_xfers("t8_xfer", 1, 20);
    idle(3);
    g = xget(0);
    check("t8_sum", g.sum, 21);
    check("t8_min", g.mn, 1);
    check("t8_max", g.mx, 6);
    check("t8_errs", ovfs.size() + tmos.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
